// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment pattern decoder.
//   - SEG_0..SEG_9 : active-high segment patterns (bits G..A) for digits 0..9
//   - state_t      : reading FSM state encoding
//   - STABLE_CYCLES_DEF : default settle length in synchronized samples
package seg_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/seg_pattern_decoder_if.sv
// seg_pattern_decoder_if: valid/ready reading channel of the decoder.
//   dout_valid : reading available (producer -> consumer)
//   dout_ready : consumer accepts reading (consumer -> producer)
//   dout_value : tens*10+ones, 0..99
//   dout_err   : reading contained an illegal segment pattern
interface seg_pattern_decoder_if;
  logic       dout_valid;
  logic       dout_ready;
  logic [6:0] dout_value;
  logic       dout_err;

  modport master (
    output dout_valid,
    output dout_value,
    output dout_err,
    input  dout_ready
  );

  modport slave (
    input  dout_valid,
    input  dout_value,
    input  dout_err,
    output dout_ready
  );
endinterface

// File: rtl/seg_digit_decode.sv
// seg_digit_decode: combinational seven-segment pattern to BCD digit.
//   pattern : segments G..A
//   digit   : decoded digit 0..9 (0 when illegal)
//   illegal : pattern is not one of the ten digit shapes
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       illegal
);

  always_comb begin
    digit   = 4'd0;
    illegal = 1'b0;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_pattern_decoder.sv
// seg_pattern_decoder: debounced two-digit seven-segment reader.
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   seg_led_1  : tens digit bus {DIG, DP, G..A}
//   seg_led_2  : ones digit bus, same order
//   dout       : valid/ready reading channel (master side)
//
// state  | meaning
// IDLE   | first edge after reset, capture reference
// SETTLE | counting consecutive equal samples against reference
// REPORT | reading presented, waiting for dout_ready
// HOLD   | reading delivered, waiting for the display to change
module seg_pattern_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [8:0]                    seg_led_1,
  input  logic [8:0]                    seg_led_2,
  seg_pattern_decoder_if.master         dout
);

  localparam logic [7:0] CNT_TC  = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_MAX = 8'hFF;

  // {tens bus, ones bus}; DIG/DP take part in the stability compare
  logic [17:0] sync1_q, sync2_q;
  logic [17:0] ref_q, ref_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  value_q, value_d;
  logic        err_q, err_d;
  state_t      state_q, state_d;

  logic [3:0]  tens_digit, ones_digit;
  logic        tens_illegal, ones_illegal;
  logic        pair_same;
  logic [6:0]  sum_value;

  seg_digit_decode u_tens (
    .pattern (sync2_q[15:9]),
    .digit   (tens_digit),
    .illegal (tens_illegal)
  );

  seg_digit_decode u_ones (
    .pattern (sync2_q[6:0]),
    .digit   (ones_digit),
    .illegal (ones_illegal)
  );

  assign sum_value = ({3'b000, tens_digit} * 7'd10) + {3'b000, ones_digit};
  assign pair_same = (sync2_q == ref_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      ref_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      err_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync1_q <= {seg_led_1, seg_led_2};
      sync2_q <= sync1_q;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        ref_d   = sync2_q;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (!pair_same) begin
          ref_d = sync2_q;
          cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
          err_d   = tens_illegal | ones_illegal;
          value_d = (tens_illegal | ones_illegal) ? 7'd0 : sum_value;
          state_d = REPORT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REPORT: begin
        // input activity here is ignored until the reading is taken
        if (dout.dout_ready) begin
          if (pair_same) begin
            state_d = HOLD;
          end else begin
            ref_d   = sync2_q;
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end
      HOLD: begin
        if (!pair_same) begin
          ref_d   = sync2_q;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout.dout_valid = (state_q == REPORT);
  assign dout.dout_value = value_q;
  assign dout.dout_err   = err_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// tb_seg_pattern_decoder: scoreboard bench for seg_pattern_decoder.
module tb_seg_pattern_decoder;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] seg_led_1 = '0;
  logic [8:0] seg_led_2 = '0;

  seg_pattern_decoder_if dout_if ();

  seg_pattern_decoder #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_led_1 (seg_led_1),
    .seg_led_2 (seg_led_2),
    .dout      (dout_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int rep_count = 0;
  logic [7:0] exp_q[$];

  // {illegal, digit}
  function automatic logic [4:0] digit_of(input logic [6:0] p);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    for (int i = 0; i < 10; i++) if (p == tbl[i]) return {1'b0, 4'(i)};
    return 5'b10000;
  endfunction

  // {err, value}
  function automatic logic [7:0] model(input logic [8:0] a, input logic [8:0] b);
    logic [4:0] t, o;
    t = digit_of(a[6:0]);
    o = digit_of(b[6:0]);
    if (t[4] || o[4]) return 8'h80;
    return {1'b0, 7'(int'(t[3:0]) * 10 + int'(o[3:0]))};
  endfunction

  // transfer monitor: a reading that is valid and ready at the falling edge
  // is taken at the next rising edge
  always @(negedge clk) begin
    logic [7:0] got, expv;
    if (rst_n && dout_if.dout_valid && dout_if.dout_ready) begin
      got = {dout_if.dout_err, dout_if.dout_value};
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_report: got err=%0b value=%0d, required no report",
                 got[7], got[6:0]);
      end else begin
        expv = exp_q.pop_front();
        if (got !== expv) begin
          fails++;
          $display("FAIL report_value: got err=%0b value=%0d, required err=%0b value=%0d",
                   got[7], got[6:0], expv[7], expv[6:0]);
        end
      end
      rep_count++;
    end
  end

  task automatic edges_to_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!dout_if.dout_valid && n < 60);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dout_if.dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dout_if.dout_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b, required 0", dout_if.dout_valid);
    end
    checks++;
    if (dout_if.dout_value !== 7'd0) begin
      fails++; $display("FAIL reset_value: got %0d, required 0", dout_if.dout_value);
    end
    checks++;
    if (dout_if.dout_err !== 1'b0) begin
      fails++; $display("FAIL reset_err: got %b, required 0", dout_if.dout_err);
    end
  endtask

  task automatic test_basic();
    int n, base;
    base = rep_count;
    seg_led_1 = 9'h03F;
    seg_led_2 = 9'h04F;
    dout_if.dout_ready = 1'b1;
    exp_q.push_back(model(seg_led_1, seg_led_2));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edges_to_valid(n);
    checks++;
    if (n !== S + 3) begin
      fails++; $display("FAIL basic_latency: got %0d edges, required %0d", n, S + 3);
    end
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (rep_count !== base + 1) begin
      fails++; $display("FAIL basic_single_pulse: got %0d reports, required 1", rep_count - base);
    end
  endtask

  task automatic test_dp_dig();
    int n, base;
    base = rep_count;
    seg_led_1 = 9'h006;
    seg_led_2 = 9'h16F;
    exp_q.push_back(model(seg_led_1, seg_led_2));
    edges_to_valid(n);
    checks++;
    if (n !== S + 3) begin
      fails++; $display("FAIL dpdig_latency: got %0d edges, required %0d", n, S + 3);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (rep_count !== base + 1) begin
      fails++; $display("FAIL dpdig_count: got %0d reports, required 1", rep_count - base);
    end
  endtask

  task automatic test_bounce();
    int n, base;
    base = rep_count;
    for (int i = 0; i < 8; i++) begin
      seg_led_2 = (i % 2 == 0) ? 9'h05B : 9'h006;
      repeat (2) @(posedge clk);
      #1;
    end
    checks++;
    if (rep_count !== base || dout_if.dout_valid !== 1'b0) begin
      fails++; $display("FAIL bounce_quiet: got %0d reports valid=%b, required 0 reports valid=0",
                        rep_count - base, dout_if.dout_valid);
    end
    seg_led_2 = 9'h05B;
    exp_q.push_back(model(seg_led_1, seg_led_2));
    edges_to_valid(n);
    checks++;
    if (n !== S + 3) begin
      fails++; $display("FAIL bounce_latency: got %0d edges, required %0d", n, S + 3);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (rep_count !== base + 1) begin
      fails++; $display("FAIL bounce_count: got %0d reports, required 1", rep_count - base);
    end
  endtask

  task automatic test_backpressure();
    int n, base;
    logic [7:0] held;
    base = rep_count;
    dout_if.dout_ready = 1'b0;
    seg_led_1 = 9'h03F;
    seg_led_2 = 9'h006;
    exp_q.push_back(model(seg_led_1, seg_led_2));
    edges_to_valid(n);
    checks++;
    if (n !== S + 3) begin
      fails++; $display("FAIL bp_latency: got %0d edges, required %0d", n, S + 3);
    end
    held = model(seg_led_1, seg_led_2);
    seg_led_1 = 9'h07F;
    seg_led_2 = 9'h07F;
    exp_q.push_back(model(seg_led_1, seg_led_2));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (dout_if.dout_valid !== 1'b1 || {dout_if.dout_err, dout_if.dout_value} !== held) begin
        fails++;
        $display("FAIL bp_frozen: cycle %0d got valid=%b err=%0b value=%0d, required valid=1 err=%0b value=%0d",
                 i, dout_if.dout_valid, dout_if.dout_err, dout_if.dout_value, held[7], held[6:0]);
      end
    end
    dout_if.dout_ready = 1'b1;
    edges_to_valid(n);
    checks++;
    if (n !== S + 1) begin
      fails++; $display("FAIL bp_next_latency: got %0d edges, required %0d", n, S + 1);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (rep_count !== base + 2) begin
      fails++; $display("FAIL bp_count: got %0d reports, required 2", rep_count - base);
    end
  endtask

  task automatic test_illegal();
    int n;
    seg_led_1 = 9'h03F;
    seg_led_2 = 9'h055;
    exp_q.push_back(model(seg_led_1, seg_led_2));
    edges_to_valid(n);
    checks++;
    if (n !== S + 3) begin
      fails++; $display("FAIL illegal_latency: got %0d edges, required %0d", n, S + 3);
    end
    checks++;
    if (dout_if.dout_err !== 1'b1 || dout_if.dout_value !== 7'd0) begin
      fails++; $display("FAIL illegal_outputs: got err=%b value=%0d, required err=1 value=0",
                        dout_if.dout_err, dout_if.dout_value);
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int n;
    dout_if.dout_ready = 1'b0;
    seg_led_1 = 9'h04F;
    seg_led_2 = 9'h066;
    edges_to_valid(n);
    checks++;
    if (n !== S + 3) begin
      fails++; $display("FAIL rstmid_latency: got %0d edges, required %0d", n, S + 3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_if.dout_valid !== 1'b0 || dout_if.dout_value !== 7'd0 || dout_if.dout_err !== 1'b0) begin
      fails++; $display("FAIL rstmid_async: got valid=%b value=%0d err=%b, required all 0",
                        dout_if.dout_valid, dout_if.dout_value, dout_if.dout_err);
    end
    repeat (3) @(posedge clk);
    #1;
    dout_if.dout_ready = 1'b1;
    exp_q.push_back(model(seg_led_1, seg_led_2));
    rst_n = 1'b1;
    edges_to_valid(n);
    checks++;
    if (n !== S + 3) begin
      fails++; $display("FAIL rstmid_restart: got %0d edges, required %0d", n, S + 3);
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    dout_if.dout_ready = 1'b0;
    test_reset();
    test_basic();
    test_dp_dig();
    test_bounce();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_pattern_decoder.md
SEG_PATTERN_DECODER -- requirements
Module: seg_pattern_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 1..255: consecutive equal synchronized samples required before a reading is reported.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port seg_led_1  input  9  tens-digit bus, bits MSB..LSB = DIG, DP, G, F, E, D, C, B, A.
REQ-005 SHALL have port seg_led_2  input  9  ones-digit bus, same bit order.
REQ-006 SHALL have port dout_valid  output  1  reading available.
REQ-007 SHALL have port dout_ready  input  1  consumer accepts reading.
REQ-008 SHALL have port dout_value  output  7  decoded value tens*10+ones, 0..99.
REQ-009 SHALL have port dout_err  output  1  reading contained an illegal pattern.

Function
REQ-010 SHALL pass both 9-bit buses through a 2-flop synchronizer; only the second stage feeds downstream logic.
REQ-011 SHALL decode only bits [6:0] of each bus; DIG and DP are ignored.
REQ-012 SHALL map 7-bit patterns 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F to digits 0..9; any other pattern, including 0x00, is illegal.
REQ-013 SHALL compute dout_value as tens*10+ones in 7 bits, no truncation.
REQ-014 SHALL, when either digit is illegal, report dout_err=1 and dout_value=0.
REQ-015 SHALL implement states IDLE, SETTLE, REPORT, HOLD.
REQ-016 IDLE: on the first edge after reset, load the synchronized pair as reference, clear counter, go to SETTLE.
REQ-017 SETTLE: each edge, if synchronized pair differs from reference, load it as new reference and clear counter; else increment counter; when counter reaches STABLE_CYCLES-1 and the pair is still equal, register value/err and go to REPORT.
REQ-018 REPORT: dout_valid=1; dout_value and dout_err SHALL NOT change while dout_valid=1 and dout_ready=0, regardless of input activity.
REQ-019 Handshake: a reading transfers on an edge with dout_valid=1 and dout_ready=1; dout_valid deasserts on that edge.
REQ-020 After transfer: go to HOLD if the synchronized pair equals the reported reference, else load new reference, clear counter, go to SETTLE.
REQ-021 HOLD: stay while pair equals reported reference (no duplicate reports); on any difference load it as reference, clear counter, go to SETTLE.
REQ-022 Input changes during REPORT SHALL be evaluated only after transfer per REQ-020; intermediate values are discarded.
REQ-023 dout_ready while dout_valid=0 SHALL have no effect.
REQ-024 Latency: a single input change held steady yields dout_valid=1 exactly STABLE_CYCLES+3 rising edges after the change is first sampled by sync stage 1 (2 sync + STABLE_CYCLES settle + 1 register), with the block in SETTLE or HOLD.
REQ-025 Counter SHALL saturate and never wrap; its width is 8 bits.

Reset
REQ-026 rst_n low SHALL asynchronously force dout_valid=0, dout_value=0, dout_err=0, state IDLE, counter 0, synchronizer and reference registers 0.
REQ-027 Reset asserted mid-REPORT SHALL drop dout_valid immediately with no transfer; after release the block restarts from IDLE.

Structure
REQ-028 Package seg_pkg SHALL hold the ten segment-pattern constants, the state type, and the STABLE_CYCLES default.
REQ-029 A combinational sub-module seg_digit_decode (7-bit pattern in, 4-bit digit and illegal flag out) SHALL be instantiated twice.

Verification
REQ-030 Reset, then seg_led_1=0x03F, seg_led_2=0x04F steady, dout_ready=1 -> one valid pulse, value=3, err=0, at edge STABLE_CYCLES+3 after first sample; no further pulses.
REQ-031 seg_led_1=0x006, seg_led_2=0x16F (DP/DIG set) -> value=19, err=0.
REQ-032 seg_led_2 toggles 0x06/0x5B every 2 cycles with STABLE_CYCLES=4 -> no dout_valid; stop toggling on 0x5B -> one report of the matching value.
REQ-033 dout_ready=0 for 10 cycles during REPORT while inputs change to 0x07F/0x07F -> value frozen; after accept, new report value=88.
REQ-034 seg_led_1=0x03F, seg_led_2=0x055 -> dout_err=1, dout_value=0.
REQ-035 Drive rst_n low while dout_valid=1 -> all outputs 0 without a clock edge; release -> fresh report after STABLE_CYCLES+3 edges.
